// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI transfer sequencer and its TX FIFO.
package spi_ctrl_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_UNLOAD = 3'd3,
    ST_STORE  = 3'd4,
    ST_GAP    = 3'd5
  } state_e;

  // Terminal value of a phase counter that starts at zero on phase entry.
  function automatic logic [CNT_W-1:0] last_count(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// DEPTH x BYTE_W synchronous FIFO holding bytes waiting for the shifter.
module spi_tx_fifo
  import spi_ctrl_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_head,
  output logic [CW-1:0]     o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == {CW{1'b0}});
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {BYTE_W{1'b0}};
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Byte transaction sequencer: feeds the SPI shifter from a TX FIFO, captures
// each received byte and spaces transfers so slave-select drops between bytes.
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int SHIFT_CYCLES = 8,
  parameter int GAP_CYCLES   = 2
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              clear_err,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_full,
  output logic              tx_empty,
  output logic              busy,
  output logic              overflow,
  output logic              overrun,
  output logic              spi_load,
  output logic              spi_unload,
  output logic [BYTE_W-1:0] spi_datain,
  input  logic [BYTE_W-1:0] spi_dataout
);

  localparam int               CW         = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = last_count(SHIFT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST   = last_count(GAP_CYCLES);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [BYTE_W-1:0] r_datain;
  logic [BYTE_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_overflow;
  logic              r_overrun;
  logic [BYTE_W-1:0] w_head;
  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_load;
  logic              w_unload;
  logic              w_busy;
  logic              w_store;

  spi_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (clock_in),
    .i_rst_n (reset_n),
    .i_push  (wr_en),
    .i_data  (wr_data),
    .i_pop   (w_load),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // enable is only consulted in IDLE, so a started byte always runs to the end of GAP.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_unload    = 1'b0;
    w_busy      = 1'b1;
    w_store     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (enable && (w_count != {CW{1'b0}})) w_state_nxt = ST_LOAD;
        else                                   w_state_nxt = ST_IDLE;
      end
      ST_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (r_cnt == SHIFT_LAST) w_state_nxt = ST_UNLOAD;
        else                     w_state_nxt = ST_SHIFT;
      end
      ST_UNLOAD: begin
        w_unload    = 1'b1;
        w_state_nxt = ST_STORE;
      end
      ST_STORE: begin
        w_store     = 1'b1;
        w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) w_state_nxt = ST_IDLE;
        else                   w_state_nxt = ST_GAP;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n)                                  r_cnt <= {CNT_W{1'b0}};
    else if (w_state_nxt != r_state)               r_cnt <= {CNT_W{1'b0}};
    else if (r_state == ST_SHIFT || r_state == ST_GAP) r_cnt <= r_cnt + CNT_W'(1);
    else                                           r_cnt <= r_cnt;
  end

  // Head is captured on entry to LOAD; it cannot move until the pop at LOAD exit.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n)                                           r_datain <= {BYTE_W{1'b0}};
    else if (r_state == ST_IDLE && w_state_nxt == ST_LOAD)  r_datain <= w_head;
    else                                                    r_datain <= r_datain;
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_data  <= {BYTE_W{1'b0}};
      r_rx_valid <= 1'b0;
    end else if (w_store) begin
      r_rx_data  <= spi_dataout;
      r_rx_valid <= 1'b1;
    end else if (rd_en) begin
      r_rx_valid <= 1'b0;
    end
  end

  // Sticky flags: a set in the same cycle as clear_err takes priority.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (wr_en && w_full)                      r_overflow <= 1'b1;
      else if (clear_err)                       r_overflow <= 1'b0;
      if (w_store && r_rx_valid && !rd_en)      r_overrun  <= 1'b1;
      else if (clear_err)                       r_overrun  <= 1'b0;
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign tx_full    = w_full;
  assign tx_empty   = w_empty;
  assign busy       = w_busy;
  assign overflow   = r_overflow;
  assign overrun    = r_overrun;
  assign spi_load   = w_load;
  assign spi_unload = w_unload;
  assign spi_datain = r_datain;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a latch model of the shifter's dataout.
module tb_spi_xfer_ctrl;

  logic       clock_in = 1'b0;
  logic       reset_n  = 1'b1;
  logic       enable   = 1'b0;
  logic       wr_en    = 1'b0;
  logic [7:0] wr_data  = 8'h00;
  logic       rd_en    = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, tx_full, tx_empty, busy, overflow, overrun;
  logic       spi_load, spi_unload;
  logic [7:0] spi_datain;
  logic [7:0] spi_dataout;

  int errors = 0;
  int checks = 0;

  always #5 clock_in = ~clock_in;

  spi_xfer_ctrl #(.DEPTH(4), .SHIFT_CYCLES(8), .GAP_CYCLES(2)) dut (
    .clock_in(clock_in), .reset_n(reset_n), .enable(enable), .wr_en(wr_en),
    .wr_data(wr_data), .rd_en(rd_en), .clear_err(clear_err), .rx_data(rx_data),
    .rx_valid(rx_valid), .tx_full(tx_full), .tx_empty(tx_empty), .busy(busy),
    .overflow(overflow), .overrun(overrun), .spi_load(spi_load),
    .spi_unload(spi_unload), .spi_datain(spi_datain), .spi_dataout(spi_dataout)
  );

  // Shifter model: received byte is the loaded byte XOR 0x99, transparent during unload.
  always_latch begin
    if (spi_unload) spi_dataout <= spi_datain ^ 8'h99;
  end

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 1'b0; rd_en = 1'b0; clear_err = 1'b0; enable = 1'b0;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, spi_load, spi_unload, rx_valid, tx_empty, tx_full, overflow, overrun} !== 8'b0000_1000) begin
      $display("FAIL reset_flags: got %b expected 00001000", {busy, spi_load, spi_unload, rx_valid, tx_empty, tx_full, overflow, overrun});
      errors++;
    end
    checks++;
    if (spi_datain !== 8'h00 || rx_data !== 8'h00) begin
      $display("FAIL reset_data: datain=%h rx_data=%h expected 00/00", spi_datain, rx_data);
      errors++;
    end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || tx_empty !== 1'b1) begin
      $display("FAIL reset_release: busy=%b tx_empty=%b expected 0/1", busy, tx_empty);
      errors++;
    end
  endtask

  task automatic test_single_byte();
    logic [3:0] exp_v;
    do_reset();
    enable = 1'b1; wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL single_edge0_busy: got %b expected 0", busy);
      errors++;
    end
    for (int e = 1; e <= 15; e++) begin
      tick();
      exp_v = {(e == 1), (e == 10), (e >= 12), (e <= 13)};
      checks++;
      if ({spi_load, spi_unload, rx_valid, busy} !== exp_v) begin
        $display("FAIL single_timeline edge%0d: load/unload/valid/busy=%b expected %b", e, {spi_load, spi_unload, rx_valid, busy}, exp_v);
        errors++;
      end
      if (e == 1 || e == 5) begin
        checks++;
        if (spi_datain !== 8'hA5) begin
          $display("FAIL single_datain edge%0d: got %h expected a5", e, spi_datain);
          errors++;
        end
      end
    end
    checks++;
    if (rx_data !== 8'h3C || tx_empty !== 1'b1) begin
      $display("FAIL single_rx: rx_data=%h tx_empty=%b expected 3c/1", rx_data, tx_empty);
      errors++;
    end
  endtask

  task automatic test_burst_full();
    int nloads;
    int last_cyc;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      tick();
      checks++;
      if ({tx_full, overflow} !== {(i >= 3), (i == 4)}) begin
        $display("FAIL burst_fill write%0d: full/overflow=%b expected %b", i + 1, {tx_full, overflow}, {(i >= 3), (i == 4)});
        errors++;
      end
    end
    wr_en = 1'b0; clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      $display("FAIL burst_clear: overflow=%b expected 0", overflow);
      errors++;
    end
    wr_en = 1'b1; wr_data = 8'hEE; clear_err = 1'b1;
    tick();
    wr_en = 1'b0; clear_err = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      $display("FAIL burst_set_beats_clear: overflow=%b expected 1", overflow);
      errors++;
    end
    enable = 1'b1;
    nloads = 0; last_cyc = 0;
    for (int c = 0; c < 70; c++) begin
      tick();
      if (spi_load === 1'b1) begin
        checks++;
        if (spi_datain !== 8'(nloads + 1)) begin
          $display("FAIL burst_load_data #%0d: got %h expected %h", nloads, spi_datain, 8'(nloads + 1));
          errors++;
        end
        if (nloads > 0) begin
          checks++;
          if (c - last_cyc != 14) begin
            $display("FAIL burst_spacing #%0d: got %0d expected 14", nloads, c - last_cyc);
            errors++;
          end
        end
        last_cyc = c;
        nloads++;
      end
    end
    checks++;
    if (nloads != 4 || tx_empty !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL burst_end: loads=%0d empty=%b busy=%b expected 4/1/0", nloads, tx_empty, busy);
      errors++;
    end
  endtask

  task automatic test_overrun();
    int nunl;
    do_reset();
    enable = 1'b1;
    wr_en = 1'b1; wr_data = 8'h11; tick();
    wr_data = 8'h22; tick();
    wr_en = 1'b0;
    repeat (30) tick();
    checks++;
    if ({rx_valid, overrun} !== 2'b11 || rx_data !== (8'h22 ^ 8'h99)) begin
      $display("FAIL overrun_set: valid/overrun=%b rx=%h expected 11/%h", {rx_valid, overrun}, rx_data, 8'h22 ^ 8'h99);
      errors++;
    end
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      $display("FAIL overrun_clear: got %b expected 0", overrun);
      errors++;
    end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin
      $display("FAIL overrun_rd_clears_valid: got %b expected 0", rx_valid);
      errors++;
    end
    wr_en = 1'b1; wr_data = 8'h5A; tick();
    wr_data = 8'hC3; tick();
    wr_en = 1'b0;
    nunl = 0;
    for (int c = 0; c < 40 && nunl < 2; c++) begin
      tick();
      if (spi_unload === 1'b1) nunl++;
    end
    checks++;
    if (nunl != 2) begin
      $display("FAIL overrun_wait_unload: saw %0d unloads expected 2", nunl);
      errors++;
    end
    tick();
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    checks++;
    if ({rx_valid, overrun} !== 2'b10 || rx_data !== (8'hC3 ^ 8'h99)) begin
      $display("FAIL overrun_rd_same_cycle: valid/overrun=%b rx=%h expected 10/%h", {rx_valid, overrun}, rx_data, 8'hC3 ^ 8'h99);
      errors++;
    end
  endtask

  task automatic test_enable_drop();
    int nloads;
    do_reset();
    enable = 1'b1; nloads = 0;
    wr_en = 1'b1; wr_data = 8'h81; tick();
    wr_data = 8'h42; tick();
    wr_en = 1'b0;
    if (spi_load === 1'b1) nloads++;
    repeat (3) begin
      tick();
      if (spi_load === 1'b1) nloads++;
    end
    enable = 1'b0;
    repeat (30) begin
      tick();
      if (spi_load === 1'b1) nloads++;
    end
    checks++;
    if (nloads != 1 || rx_valid !== 1'b1 || rx_data !== (8'h81 ^ 8'h99) || tx_empty !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL enable_drop_hold: loads=%0d valid=%b rx=%h empty=%b busy=%b expected 1/1/%h/0/0", nloads, rx_valid, rx_data, tx_empty, busy, 8'h81 ^ 8'h99);
      errors++;
    end
    enable = 1'b1;
    repeat (5) begin
      tick();
      if (spi_load === 1'b1) begin
        nloads++;
        checks++;
        if (spi_datain !== 8'h42) begin
          $display("FAIL enable_resume_data: got %h expected 42", spi_datain);
          errors++;
        end
      end
    end
    checks++;
    if (nloads != 2) begin
      $display("FAIL enable_resume_loads: got %0d expected 2", nloads);
      errors++;
    end
  endtask

  task automatic test_async_reset();
    int nloads;
    repeat (20) tick();
    wr_en = 1'b1; wr_data = 8'h77; tick();
    wr_en = 1'b0;
    repeat (4) tick();
    checks++;
    if (busy !== 1'b1 || spi_datain !== 8'h77) begin
      $display("FAIL areset_pre: busy=%b datain=%h expected 1/77", busy, spi_datain);
      errors++;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, spi_load, spi_unload, rx_valid, tx_empty, tx_full, overflow, overrun} !== 8'b0000_1000 || spi_datain !== 8'h00 || rx_data !== 8'h00) begin
      $display("FAIL areset_immediate: flags=%b datain=%h rx=%h expected 00001000/00/00", {busy, spi_load, spi_unload, rx_valid, tx_empty, tx_full, overflow, overrun}, spi_datain, rx_data);
      errors++;
    end
    #3 reset_n = 1'b1;
    nloads = 0;
    repeat (20) begin
      tick();
      if (spi_load === 1'b1) nloads++;
    end
    checks++;
    if (nloads != 0 || rx_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL areset_after: loads=%0d valid=%b busy=%b expected 0/0/0", nloads, rx_valid, busy);
      errors++;
    end
  endtask

  task automatic test_wrap();
    int written;
    int nloads;
    do_reset();
    enable = 1'b1; written = 0; nloads = 0;
    for (int c = 0; c < 400 && nloads < 10; c++) begin
      if (spi_load === 1'b1) begin
        checks++;
        if (spi_datain !== 8'(8'h30 + nloads)) begin
          $display("FAIL wrap_order #%0d: got %h expected %h", nloads, spi_datain, 8'(8'h30 + nloads));
          errors++;
        end
        nloads++;
      end
      if (written < 10 && tx_full !== 1'b1) begin
        wr_en = 1'b1; wr_data = 8'(8'h30 + written); written++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    checks++;
    if (nloads != 10 || written != 10 || overflow !== 1'b0) begin
      $display("FAIL wrap_end: loads=%0d written=%0d overflow=%b expected 10/10/0", nloads, written, overflow);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst_full();
    test_overrun();
    test_enable_drop();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
